// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters sharing one decoded resource slot.
// Registered 3-bit owner index with bounded hold time and a one-cycle turnaround gap.
module rr_arbiter_8 #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_vld,
    output logic                 timeout
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [7:0]    hold_cnt;
    logic          vld_q;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    // First requester found searching last+1, last+2, ... wrapping mod N.
    function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] from);
        logic          found;
        logic [IW-1:0] idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(from) + k) % N);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        {pick_vld, pick_idx} = pick(req, last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IW'(N - 1);
            hold_cnt  <= '0;
            vld_q     <= 1'b0;
            grant_idx <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (en) begin
                case (state)
                    // GAP is the single turnaround cycle; its exit edge arbitrates like IDLE.
                    IDLE, GAP: begin
                        if (pick_vld) begin
                            grant_idx <= pick_idx;
                            vld_q     <= 1'b1;
                            hold_cnt  <= 8'd1;
                            state     <= GRANT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    GRANT: begin
                        if (!req[grant_idx]) begin
                            last  <= grant_idx;
                            vld_q <= 1'b0;
                            state <= GAP;
                        end else if (hold_cnt == 8'(MAX_HOLD)) begin
                            last    <= grant_idx;
                            vld_q   <= 1'b0;
                            timeout <= 1'b1;
                            state   <= GAP;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign grant_vld = vld_q & en;
    assign grant     = (en && vld_q) ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed stimulus pushes expected outputs,
// a monitor pops and compares one entry per clock.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] req1;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic       timeout;
    logic [7:0] grant1;
    logic [2:0] grant_idx1;
    logic       grant_vld1;
    logic       timeout1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
        logic       ci;
        logic [7:0] g1;
        logic       v1;
        logic       to1;
    } exp_t;

    exp_t q[$];

    rr_arbiter_8 #(.N(8), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .timeout   (timeout)
    );

    rr_arbiter_8 #(.N(8), .MAX_HOLD(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req1),
        .grant     (grant1),
        .grant_idx (grant_idx1),
        .grant_vld (grant_vld1),
        .timeout   (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    // v / v1 are the owner-valid states before en masking.
    task automatic cyc(input logic [7:0] r, input logic e, input logic rn,
                       input logic [2:0] idx, input logic v, input logic to, input logic ci,
                       input logic [7:0] r1, input logic v1, input logic to1);
        exp_t x;
        @(negedge clk);
        req   = r;
        en    = e;
        rst_n = rn;
        req1  = r1;
        x.idx = idx;
        x.v   = v & e;
        x.g   = (v && e) ? (8'h01 << idx) : 8'h00;
        x.to  = to;
        x.ci  = ci;
        x.v1  = v1 & e;
        x.g1  = (v1 && e) ? 8'h01 : 8'h00;
        x.to1 = to1;
        q.push_back(x);
    endtask

    task automatic c0(input logic [7:0] r, input logic rn, input logic [2:0] idx,
                      input logic v, input logic to, input logic ci);
        cyc(r, 1'b1, rn, idx, v, to, ci, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("grant", grant, x.g);
                chk("grant_vld", {7'b0, grant_vld}, {7'b0, x.v});
                chk("timeout", {7'b0, timeout}, {7'b0, x.to});
                if (x.ci) chk("grant_idx", {5'b0, grant_idx}, {5'b0, x.idx});
                chk("grant1", grant1, x.g1);
                chk("grant_vld1", {7'b0, grant_vld1}, {7'b0, x.v1});
                chk("timeout1", {7'b0, timeout1}, {7'b0, x.to1});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'h00;
        req1  = 8'h00;

        // Reset, then idle with no requests.
        repeat (2) c0(8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        repeat (5) c0(8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);

        // 0 and 7 request: 0 first, then 7 after one gap cycle.
        repeat (4) c0(8'h81, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        c0(8'h80, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) c0(8'h80, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1);

        // Owner 7 releases with 0,1 requesting: wrap to 0, then 1.
        c0(8'h03, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        repeat (2) c0(8'h03, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        c0(8'h02, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        c0(8'h02, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        c0(8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        c0(8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);

        // All requesting: each owner holds 16 cycles, then timeout + gap.
        c0(8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            repeat (16) c0(8'hFF, 1'b1, 3'(k), 1'b1, 1'b0, 1'b1);
            c0(8'hFF, 1'b1, 3'(k), 1'b0, 1'b1, 1'b0);
        end

        // Owner 0 again; en low for 3 cycles freezes the hold count.
        repeat (5) c0(8'hFF, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc(8'hFF, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        repeat (11) c0(8'hFF, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        c0(8'hFF, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        c0(8'hFF, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);

        // Reset during owner 5, then re-grant 5.
        c0(8'h20, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) c0(8'h20, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        c0(8'h20, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) c0(8'h20, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);

        // Drop 5 and raise 3 together: release, gap, then 3.
        c0(8'h08, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        c0(8'h08, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
        c0(8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        c0(8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);

        // MAX_HOLD=1 instance: lone requester alternates grant / timeout.
        for (int i = 0; i < 6; i++)
            cyc(8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h01, (i % 2 == 0), (i % 2 == 1));
        cyc(8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
